// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC and fetches over a req/ack instruction-memory handshake.
// A one-entry buffer parks a fetched word while decode is stalled.
// Redirects from decode flush IF/ID. A wrong-path fetch that is still
// in flight is drained and its data dropped.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        stop,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D,
  output logic        fetch_empty
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target_r;
  logic        fb_valid;
  logic [31:0] fb_instr;
  logic [31:0] fb_pc4;

  logic        adv;
  logic        redir;
  logic        run;
  logic        ack_run;
  logic [31:0] pc4;

  assign adv     = !stall && !stop;
  assign redir   = redirect && valid_D && adv;
  assign run     = (state == RUN);
  assign pc4     = pc + 32'd4;

  // In DRAIN, pc still holds the wrong-path address until its ack lands,
  // so the address output stays stable for the whole request.
  assign imem_req  = !rst && ((run && !fb_valid) || !run);
  assign imem_addr = pc;

  // Only an ack for a live RUN request carries usable data.
  assign ack_run     = run && imem_ack && imem_req;
  assign fetch_empty = !fb_valid && !(run && imem_ack);

  // PC and RUN/DRAIN sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      target_r <= RESET_PC;
    end else if (run) begin
      if (redir) begin
        if (ack_run) begin
          pc <= redirect_pc;
        end else if (imem_req) begin
          target_r <= redirect_pc;
          state    <= DRAIN;
        end else begin
          pc <= redirect_pc;
        end
      end else if (ack_run) begin
        pc <= pc4;
      end
    end else if (imem_ack) begin
      pc    <= target_r;
      state <= RUN;
    end
  end

  // One-entry fetch buffer: parks a word that arrives while IF/ID cannot take it
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_valid <= 1'b0;
      fb_instr <= 32'd0;
      fb_pc4   <= 32'd0;
    end else if (redir) begin
      fb_valid <= 1'b0;
    end else if (adv && fb_valid) begin
      fb_valid <= 1'b0;
    end else if (ack_run && (!adv || fb_valid)) begin
      fb_valid <= 1'b1;
      fb_instr <= imem_rdata;
      fb_pc4   <= pc4;
    end
  end

  // IF/ID register: stop > redirect flush > stall > advance
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_D    <= 32'd0;
      pc_plus4_D <= 32'd0;
      valid_D    <= 1'b0;
    end else if (stop || stall) begin
      instr_D    <= instr_D;
    end else if (redir) begin
      instr_D <= 32'd0;
      valid_D <= 1'b0;
    end else if (fb_valid) begin
      instr_D    <= fb_instr;
      pc_plus4_D <= fb_pc4;
      valid_D    <= 1'b1;
    end else if (ack_run) begin
      instr_D    <= imem_rdata;
      pc_plus4_D <= pc4;
      valid_D    <= 1'b1;
    end else begin
      instr_D <= 32'd0;
      valid_D <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors with literal expectations plus a
// cycle model (PC, queue-based fetch buffer, drain flag) checked every cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, stop, redirect;
  logic [31:0] redirect_pc;

  logic        imem_req, imem_ack, valid_D, fetch_empty;
  logic [31:0] imem_addr, imem_rdata, instr_D, pc_plus4_D;

  logic        req2, ack2, valid2, fe2;
  logic [31:0] addr2, rdata2, instr2, pc4_2;

  int nvec = 0;
  int errs = 0;
  int lat  = 0;
  int wcnt = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .stop(stop), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_D(instr_D), .pc_plus4_D(pc_plus4_D), .valid_D(valid_D),
    .fetch_empty(fetch_empty)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .stall(stall), .stop(stop), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_D(instr2), .pc_plus4_D(pc4_2), .valid_D(valid2),
    .fetch_empty(fe2)
  );

  // Memory: ack after lat wait cycles, data = addr | 0x1000
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_addr | 32'h1000;
  assign ack2       = req2;
  assign rdata2     = addr2 | 32'h1000;

  always_ff @(posedge clk) begin
    if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_tgt, m_instr, m_pc4;
  bit          m_drain, m_valid, m_live;
  logic [63:0] m_buf[$];

  task automatic model_step();
    bit          a, rd, rq, ak;
    logic [63:0] e;
    if (rst) begin
      m_pc = 32'h0; m_tgt = 32'h0; m_drain = 0; m_buf.delete();
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_live = 1;
      return;
    end
    if (!m_live) return;
    a  = !stall && !stop;
    rd = redirect && m_valid && a;
    rq = m_drain || (m_buf.size() == 0);
    ak = imem_ack && rq;
    if (m_drain) begin
      if (a) begin m_instr = 32'h0; m_valid = 0; end
      if (ak) begin m_pc = m_tgt; m_drain = 0; end
    end else if (rd) begin
      m_instr = 32'h0; m_valid = 0;
      m_buf.delete();
      if (ak)      m_pc = redirect_pc;
      else if (rq) begin m_tgt = redirect_pc; m_drain = 1; end
      else         m_pc = redirect_pc;
    end else begin
      if (a) begin
        if (m_buf.size() != 0) begin
          e = m_buf.pop_front();
          m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1;
        end else if (ak) begin
          m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1;
        end else begin
          m_instr = 32'h0; m_valid = 0;
        end
      end else if (ak) begin
        m_buf.push_back({imem_rdata, m_pc + 32'd4});
      end
      if (ak) m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    m_live = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare process: every cycle once the model has seen reset
  initial begin
    bit er;
    forever begin
      @(negedge clk);
      if (m_live) begin
        er = !rst && (m_drain || m_buf.size() == 0);
        chk("m_req", {31'd0, imem_req}, {31'd0, er});
        if (er) chk("m_addr", imem_addr, m_pc);
        chk("m_instr", instr_D, m_instr);
        chk("m_pc4", pc_plus4_D, m_pc4);
        chk("m_valid", {31'd0, valid_D}, {31'd0, m_valid});
        chk("m_empty", {31'd0, fetch_empty},
            {31'd0, (m_buf.size() == 0) && !(!m_drain && imem_ack)});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [63:0] sp, tp, rp;
    sp = 64'h0000_3C0C_0630_0C18;
    tp = 64'h0000_0081_2000_4200;
    rp = 64'h0000_1204_8108_2041;
    rst = 1; stall = 0; stop = 0; redirect = 0; redirect_pc = 0; lat = 0;
    step(); step();

    // zero-wait streaming, plus RESET_PC wrap on dut2
    rst = 0; #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, valid_D}, 32'd0);
    chk("w_addr0", addr2, 32'hFFFF_FFF8);
    step();
    chk("s_instr0", instr_D, 32'h1000);
    chk("s_pc4_0", pc_plus4_D, 32'h4);
    chk("s_valid0", {31'd0, valid_D}, 32'd1);
    chk("w_addr1", addr2, 32'hFFFF_FFFC);
    chk("w_instr0", instr2, 32'hFFFF_FFF8);
    chk("w_pc4_0", pc4_2, 32'hFFFF_FFFC);
    step();
    chk("s_instr1", instr_D, 32'h1004);
    chk("s_pc4_1", pc_plus4_D, 32'h8);
    chk("w_addr2", addr2, 32'h0);
    chk("w_pc4_1", pc4_2, 32'h0);
    step();
    chk("s_instr2", instr_D, 32'h1008);
    chk("s_pc4_2", pc_plus4_D, 32'hC);
    chk("w_pc4_2", pc4_2, 32'h4);
    chk("w_valid", {31'd0, valid2}, 32'd1);

    // 3-cycle latency: one instruction every third cycle, address held
    lat = 2;
    step();
    chk("l_bub0", {31'd0, valid_D}, 32'd0);
    chk("l_bubi", instr_D, 32'h0);
    chk("l_addr0", imem_addr, 32'hC);
    step();
    chk("l_bub1", {31'd0, valid_D}, 32'd0);
    chk("l_addr1", imem_addr, 32'hC);
    step();
    chk("l_instr", instr_D, 32'h100C);
    chk("l_pc4", pc_plus4_D, 32'h10);

    // stall while the next word arrives: buffer catches it
    stall = 1;
    step(); step(); step();
    chk("st_hold", instr_D, 32'h100C);
    chk("st_noreq", {31'd0, imem_req}, 32'd0);
    chk("st_notempty", {31'd0, fetch_empty}, 32'd0);
    stall = 0; #1;
    chk("st_gap", {31'd0, imem_req}, 32'd0);
    step();
    chk("st_fb", instr_D, 32'h1010);
    chk("st_fbpc4", pc_plus4_D, 32'h14);
    chk("st_resume", imem_addr, 32'h14);

    // redirect mid-request: drain the wrong-path fetch
    lat = 1; redirect = 1; redirect_pc = 32'h40;
    step();
    redirect = 0;
    chk("dr_valid", {31'd0, valid_D}, 32'd0);
    chk("dr_addr", imem_addr, 32'h14);
    step();
    chk("dr_tgt", imem_addr, 32'h40);
    chk("dr_valid2", {31'd0, valid_D}, 32'd0);
    step(); step();
    chk("dr_load", instr_D, 32'h1040);
    chk("dr_pc4", pc_plus4_D, 32'h44);

    // redirect with ack in the same cycle
    lat = 0; redirect = 1; redirect_pc = 32'h80;
    step();
    redirect = 0;
    chk("ra_valid", {31'd0, valid_D}, 32'd0);
    chk("ra_addr", imem_addr, 32'h80);
    step();
    chk("ra_load", instr_D, 32'h1080);

    // redirect during stall is ignored
    redirect = 1; redirect_pc = 32'h200; stall = 1;
    step();
    chk("rs_hold", instr_D, 32'h1080);
    chk("rs_pc", imem_addr, 32'h88);
    redirect = 0; stall = 0;
    step();
    chk("rs_fb", instr_D, 32'h1084);
    chk("rs_addr", imem_addr, 32'h88);

    // stop freezes IF/ID, request still completes into the buffer
    stop = 1;
    step(); step();
    chk("sp_hold", instr_D, 32'h1084);
    chk("sp_noreq", {31'd0, imem_req}, 32'd0);
    stop = 0;
    step();
    chk("sp_fb", instr_D, 32'h1088);
    chk("sp_pc4", pc_plus4_D, 32'h8C);

    // mixed pattern, checked by the model
    for (int i = 0; i < 48; i++) begin
      lat = (i / 16) % 3;
      stall = sp[i]; stop = tp[i]; redirect = rp[i];
      redirect_pc = 32'h100 + 32'(i) * 32'h10;
      step();
    end
    stall = 0; stop = 0; redirect = 0;

    // reset while a request is pending
    lat = 2;
    step(); step();
    chk("rr_pre", {31'd0, imem_req}, 32'd1);
    rst = 1; #1;
    chk("rr_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("rr_valid", {31'd0, valid_D}, 32'd0);
    chk("rr_instr", instr_D, 32'h0);
    rst = 0; #1;
    chk("rr_addr", imem_addr, 32'h0);
    chk("rr_req2", {31'd0, imem_req}, 32'd1);
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
